// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round constants, state/word types
// and the GF(2^8) doubling helper used by MixColumns.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    // Round counter: LOAD takes in a new block, ROUND1..ROUND10 run the cipher.
    typedef enum logic [3:0] {
        LOAD    = 4'd0,
        ROUND1  = 4'd1,
        ROUND2  = 4'd2,
        ROUND3  = 4'd3,
        ROUND4  = 4'd4,
        ROUND5  = 4'd5,
        ROUND6  = 4'd6,
        ROUND7  = 4'd7,
        ROUND8  = 4'd8,
        ROUND9  = 4'd9,
        ROUND10 = 4'd10
    } round_e;

    // Round constants indexed directly by the round number. Entry 0 and the
    // entries above 10 are never used by a real round and are held at zero,
    // so the table can be indexed by the raw 4-bit counter.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift plus conditional XOR).
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: purely combinational 8-bit table lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_main.sv
// Iterative AES-128 encryption core: one round per clock through a single
// round unit, with the round key expanded on the fly alongside the state.
// A block is taken in on the LOAD cycle and its ciphertext appears 11 clocks
// later with a one-cycle block_finish pulse; new blocks follow back to back.
module aes_main
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] i_block,
    input  logic [127:0] init_key,
    output logic [127:0] o_block,
    output logic         block_finish
);

    localparam round_e LAST_ROUND = round_e'(4'(NUM_ROUNDS));

    // Byte i of a 128-bit value (FIPS-197 order) sits at bits [127-8i -: 8];
    // state row r, column c is byte r+4c.

    // Rotate row r left by r positions.
    function automatic state_t shift_rows(input state_t s);
        state_t res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return res;
    endfunction

    // Multiply each column by the fixed {02,03,01,01} circulant matrix.
    function automatic state_t mix_columns(input state_t s);
        state_t res;
        byte_t  a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return res;
    endfunction

    // One key-schedule step: sub_rot is SubWord(RotWord(w3)) from the S-boxes.
    function automatic state_t next_round_key(input state_t k, input word_t sub_rot,
                                              input byte_t rc);
        word_t t, n0, n1, n2, n3;
        t  = sub_rot ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    round_e cnt_q, cnt_d;
    state_t state_q, state_d;
    state_t key_q, key_d;
    state_t o_block_q, o_block_d;
    logic   finish_q, finish_d;

    state_t sub_bytes;
    word_t  rot_word;
    word_t  sub_rot;
    state_t key_next;
    state_t shifted;
    state_t round_out;
    logic   final_round;

    // SubBytes on the whole state: 16 parallel S-box lookups.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
            aes_sbox u_sbox (
                .byte_i (state_q[127-8*gi -: 8]),
                .byte_o (sub_bytes[127-8*gi -: 8])
            );
        end
    endgenerate

    // SubWord(RotWord(w3)) for the key schedule: 4 more S-box lookups.
    assign rot_word = {key_q[23:0], key_q[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
            aes_sbox u_sbox (
                .byte_i (rot_word[31-8*gi -: 8]),
                .byte_o (sub_rot[31-8*gi -: 8])
            );
        end
    endgenerate

    assign final_round = (cnt_q == LAST_ROUND);
    assign key_next    = next_round_key(key_q, sub_rot, RCON[cnt_q]);
    assign shifted     = shift_rows(sub_bytes);
    assign round_out   = (final_round ? shifted : mix_columns(shifted)) ^ key_next;

    // Next-state logic: load a new block, run a round, or finish the block.
    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        key_d     = key_q;
        o_block_d = o_block_q;
        finish_d  = 1'b0;
        if (cnt_q == LOAD) begin
            state_d = i_block ^ init_key;
            key_d   = init_key;
            cnt_d   = ROUND1;
        end else if (cnt_q > LAST_ROUND) begin
            // Unreachable encodings recover to LOAD without producing output.
            cnt_d = LOAD;
        end else begin
            state_d = round_out;
            key_d   = key_next;
            if (final_round) begin
                cnt_d     = LOAD;
                o_block_d = round_out;
                finish_d  = 1'b1;
            end else begin
                cnt_d = round_e'(cnt_q + 4'd1);
            end
        end
    end

    // State, key, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= LOAD;
            state_q   <= '0;
            key_q     <= '0;
            o_block_q <= '0;
            finish_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            key_q     <= key_d;
            o_block_q <= o_block_d;
            finish_q  <= finish_d;
        end
    end

    assign o_block      = o_block_q;
    assign block_finish = finish_q;

endmodule

// File: tb/tb_aes_main.sv
// Scoreboard bench for aes_main: the stimulus process pushes the expected
// ciphertext and due cycle for each LOAD, the monitor pops and compares.
module tb_aes_main;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] i_block;
    logic [127:0] init_key;
    logic [127:0] o_block;
    logic         block_finish;

    typedef struct {
        logic [127:0] exp;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           edge_idx = -1;
    int           blk = 0;
    logic [127:0] last_exp = '0;
    logic [127:0] incr_key;
    logic [7:0]   sbox_t [256];

    always #5 clk = ~clk;

    aes_main dut (
        .clk          (clk),
        .reset        (reset),
        .i_block      (i_block),
        .init_key     (init_key),
        .o_block      (o_block),
        .block_finish (block_finish)
    );

    // Index of the most recent rising edge since reset release (first edge = 0).
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_idx <= -1;
        else        edge_idx <= edge_idx + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
                    s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                out[127-8*(r+4*c) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic is_incr_block(input int b);
        return (b >= 9 && b <= 14);
    endfunction

    // ---------------- stimulus ----------------
    // Drive the inputs for the next rising edge, then advance to the next falling edge.
    task automatic cycle_drive();
        int           n;
        logic [127:0] exp;
        exp_t         e;
        n = edge_idx + 1;
        if (n % 11 == 0) begin
            case (blk)
                0: begin
                    init_key = 128'h000102030405060708090a0b0c0d0e0f;
                    i_block  = 128'h00112233445566778899aabbccddeeff;
                    exp      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
                end
                1: begin
                    init_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
                    i_block  = 128'h3243f6a8885a308d313198a2e0370734;
                    exp      = 128'h3925841d02dc09fbdc118597196a0b32;
                end
                2: begin
                    init_key = '0;
                    i_block  = '0;
                    exp      = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
                end
                default: begin
                    if (is_incr_block(blk)) begin
                        i_block  = i_block + 128'd1;
                        init_key = incr_key;
                    end else begin
                        i_block  = rand128();
                        init_key = rand128();
                    end
                    exp = aes_ref(i_block, init_key);
                end
            endcase
            e.exp = exp;
            e.due = n + 10;
            sb_q.push_back(e);
            $display("LOAD  blk=%0d edge=%0d pt=%h key=%h expect=%h", blk, n, i_block, init_key, exp);
            blk++;
        end else begin
            if (is_incr_block(blk - 1)) begin
                i_block = i_block + 128'd1;
            end else begin
                i_block  = rand128();
                init_key = rand128();
            end
        end
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        int wait_cnt;
        build_sbox();
        incr_key = rand128();
        reset    = 1'b0;
        i_block  = '0;
        init_key = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_o_block", o_block, '0);
        check_val("reset_block_finish", {127'd0, block_finish}, '0);

        // Release between edges; the next rising edge is the first LOAD.
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (8 * 11) cycle_drive();

        // Load block 8 and run it to ROUND5, then abort it with reset.
        repeat (5) cycle_drive();
        #2 reset = 1'b0;
        #1;
        check_val("abort_o_block", o_block, '0);
        check_val("abort_block_finish", {127'd0, block_finish}, '0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (8 * 11) cycle_drive();

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d blocks outstanding, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_exp = '0;
            end else if (sb_q.size() > 0 && sb_q[0].due == edge_idx) begin
                mon_e = sb_q.pop_front();
                checks++;
                if (block_finish !== 1'b1) begin
                    errors++;
                    $display("FAIL finish_pulse: edge=%0d got block_finish=%b, expected 1", edge_idx, block_finish);
                end else begin
                    checks++;
                    if (o_block !== mon_e.exp) begin
                        errors++;
                        $display("FAIL ciphertext: edge=%0d got %h, expected %h", edge_idx, o_block, mon_e.exp);
                    end else begin
                        $display("DONE  edge=%0d o_block=%h", edge_idx, o_block);
                    end
                end
                last_exp = mon_e.exp;
            end else begin
                checks++;
                if (block_finish !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_finish: edge=%0d got block_finish=%b, expected 0", edge_idx, block_finish);
                end
                checks++;
                if (o_block !== last_exp) begin
                    errors++;
                    $display("FAIL o_block_hold: edge=%0d got %h, expected %h", edge_idx, o_block, last_exp);
                end
            end
        end
    end

endmodule

// File: doc/aes_main.md
AES_MAIN -- requirements
Module: aes_main

Interface
REQ-001 SHALL have no parameters; the block is fixed AES-128 encryption with a 128-bit key, 128-bit block and 10 rounds.
REQ-002 SHALL provide: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide: i_block  input  128  plaintext block; bits [127:120] = byte 0 (state row 0, col 0); column-major byte order per FIPS-197.
REQ-005 SHALL provide: init_key  input  128  cipher key, same byte order as i_block.
REQ-006 SHALL provide: o_block  output  128  ciphertext of the most recently completed block, registered, same byte order.
REQ-007 SHALL provide: block_finish  output  1  registered one-cycle pulse, high in the cycle o_block first shows a new ciphertext.

Function
REQ-008 SHALL implement an iterative datapath with one AES round per clock, reusing a single round unit and generating round keys on the fly.
REQ-009 SHALL use a round counter with values LOAD (0) and ROUND1..ROUND10.
REQ-010 LOAD cycle SHALL sample i_block and init_key, then set state <= i_block XOR init_key, round_key <= init_key, counter <= 1.
REQ-011 ROUND1..ROUND9 SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey with the next expanded key; round key register <= next key.
REQ-012 ROUND10 SHALL omit MixColumns, load the result into o_block, set block_finish for the following cycle, and return counter to LOAD.
REQ-013 Key expansion SHALL follow FIPS-197: temp = SubWord(RotWord(w3)) XOR Rcon[r], with Rcon = 01,02,04,08,10,20,40,80,1b,36 for r = 1..10; w0..w3 are chained XORs.
REQ-014 Latency SHALL be 11 clocks from the LOAD sampling edge to o_block valid; throughput SHALL be one block every 11 clocks, with back-to-back blocks requiring no handshake.
REQ-015 i_block and init_key changes outside the LOAD cycle SHALL be ignored and SHALL NOT affect the block in flight.
REQ-016 o_block SHALL hold its value until the next ROUND10 completes; block_finish SHALL be low in all other cycles.
REQ-017 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11b, using only XOR and shift logic, with no multipliers.

Reset
REQ-018 reset low SHALL asynchronously clear o_block to 0, block_finish to 0, state and round key registers to 0, and counter to LOAD.
REQ-019 Reset asserted mid-encryption SHALL abort the block; no block_finish pulse SHALL be produced for it.
REQ-020 The first LOAD SHALL occur on the first rising clk edge after reset goes high.

Structure
REQ-021 Shared package aes_pkg SHALL hold the round-count constant (10), the Rcon table, and the state/word typedefs.
REQ-022 SHALL instantiate the sub-module aes_sbox: a combinational 8-bit lookup of the forward S-box. It SHALL be used 16 times for the state and 4 times for the key schedule.
REQ-023 ShiftRows, MixColumns and key expansion SHALL be combinational functions inside aes_main.

Verification
REQ-024 key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff -> o_block=69c4e0d86a7b0430d8cdb78070b4c55a with block_finish pulse 11 clocks after LOAD.
REQ-025 key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> o_block=3925841d02dc09fbdc118597196a0b32.
REQ-026 key=0, pt=0 -> o_block=66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-027 i_block incremented every clock while busy -> each result equals the encryption of the value sampled at its LOAD cycle; block_finish pulses every 11 clocks.
REQ-028 reset pulsed low at ROUND5 -> o_block=0 and block_finish=0 immediately; a fresh LOAD follows on the first edge after release, and the correct result arrives 11 clocks later.
REQ-029 After reset with no completed block -> o_block=0 and block_finish=0 for the first 10 clocks.
